// File: rtl/mul_shift_add_ctrl_pkg.sv
// Shared types for the iterative RV32M multiplier.
// Op encoding matches funct3[1:0] of the M-extension multiplies.
package mul_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_shift_add_ctrl_adder.sv
// Generic unsigned adder, carry-out discarded.
// Callers widen operands by one bit when they need the carry.
module mul_shift_add_ctrl_adder #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/mul_shift_add_ctrl.sv
// Shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// One adder is reused across WIDTH iterations on operand magnitudes.
module mul_shift_add_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   mul_op_t          op_q;
   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    count;
   logic             neg;

   logic             sa, sb;
   logic [WIDTH-1:0] ma, mb;
   logic [WIDTH:0]   add_s, step;
   logic [2*WIDTH-1:0] fin;

   assign sa = (op == MULH) || (op == MULHSU);
   assign sb = (op == MULH);
   assign ma = (sa && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign mb = (sb && b[WIDTH-1]) ? (~b + 1'b1) : b;

   mul_shift_add_ctrl_adder #(
      .WIDTH(WIDTH + 1)
   ) u_add (
      .a  ({1'b0, p[2*WIDTH-1:WIDTH]}),
      .b  ({1'b0, mcand}),
      .sum(add_s)
   );

   assign step = p[0] ? add_s : {1'b0, p[2*WIDTH-1:WIDTH]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_q  <= MUL;
         p     <= '0;
         mcand <= '0;
         count <= '0;
         neg   <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q  <= mul_op_t'(op);
                  mcand <= ma;
                  p     <= {{WIDTH{1'b0}}, mb};
                  neg   <= (sa && a[WIDTH-1]) ^ (sb && b[WIDTH-1]);
                  count <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               p     <= {step, p[WIDTH-1:1]};
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1))
                  state <= DONE;
            end
            DONE: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fin        = neg ? (~p + 1'b1) : p;
   assign req_ready  = (state == IDLE) && !flush;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

   always_comb begin
      result = '0;
      if (resp_valid)
         result = (op_q == MUL) ? fin[WIDTH-1:0] : fin[2*WIDTH-1:WIDTH];
   end

endmodule

// File: doc/mul_shift_add_ctrl.md
Name: mul_shift_add_ctrl

Overview:
- Iterative shift-and-add multiplier controller for the RV32M multiply ops (MUL, MULH, MULHSU, MULHU).
- Sequences a single shared adder instance over WIDTH cycles instead of using a combinational array multiplier.
- Sits beside the ALU in the execute stage; the hazard unit stalls on busy and drops in-flight work via flush.
- Uses a valid/ready handshake on both request and response.

Parameters:
WIDTH, 32, operand/result width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of any in-flight operation (pipeline flush)
req_valid  input  1  request present on op/a/b
req_ready  output  1  block can accept a request this cycle
op  input  2  multiply op: mul_op_t (MUL=0, MULH=1, MULHSU=2, MULHU=3)
a  input  WIDTH  multiplicand (rs1)
b  input  WIDTH  multiplier (rs2)
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
result  output  WIDTH  selected product half
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (synchronous, active-high) puts the FSM in IDLE and clears the product register, counter, sign flag and latched op. Reset values: req_ready=1, resp_valid=0, result=0, busy=0. Reset beats flush, which beats all else.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready = ~flush.
  - Accept on req_valid & req_ready.
  - Latch op. Signedness of a: MULH and MULHSU. Signedness of b: MULH only.
  - Latch mcand = |a| and the low product half = |b|, with magnitudes taken by two's-complement negation when the operand is signed and its MSB is set.
  - 2^(WIDTH-1) fits unsigned in WIDTH bits, so no overflow case exists.
  - neg = sign_a ^ sign_b. Upper product = 0, count = 0. Go to CALC.
- CALC (exactly WIDTH cycles):
  - Each cycle, if P[0]=1: {carry, hi} = hi + mcand through the adder instance (WIDTH+1-bit, zero-extended); else sum = {0, hi}.
  - Then P <= {carry/sum, P[2W-1:1]} (logical right shift by 1 with the carry shifted in).
  - count increments; when count == WIDTH-1, go to DONE. Count width is $clog2(WIDTH)+1.
- DONE:
  - resp_valid = 1. Final = neg ? (~P + 1) over 2*WIDTH bits : P.
  - result = final[WIDTH-1:0] for MUL, final[2W-1:W] otherwise.
  - result is combinational from registered state only and stable while resp_valid & ~resp_ready.
  - On resp_ready, go to IDLE. No back-to-back acceptance: req_ready=0 in DONE.
- Latency: acceptance at edge T gives resp_valid high in the cycle after edge T+WIDTH. That is WIDTH+1 cycles after the accepting cycle; fixed and data-independent.
- flush: from any state, go to IDLE on the next edge. The in-flight op is discarded and resp_valid is low the next cycle. flush in IDLE blocks acceptance.
- result = 0 whenever resp_valid=0.
- busy = (state != IDLE).
- Input ops are sampled only at acceptance; later input changes have no effect.

Decomposition:
- Package mul_pkg: typedef enum logic [1:0] mul_op_t {MUL, MULH, MULHSU, MULHU}; typedef enum state_t {IDLE, CALC, DONE}.
- Sub-module: one instance of the existing generic adder, with WIDTH set to WIDTH+1, for the accumulate step.
- Magnitude and final negation are inline expressions.

Test Plan:
- MUL a=7, b=6, resp_ready=1 -> result=42, resp_valid exactly 33 cycles after the accepting cycle, req_ready=0 throughout.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MUL on the same operands -> 0x00000000; MUL a=-3 (0xFFFFFFFD), b=5 -> 0xFFFFFFF1.
- a=b=0xFFFFFFFF: MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE; MULH -> 0x00000000.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid stays 1, result constant, req_valid ignored. Release -> IDLE next cycle, req_ready=1.
- Flush on the 10th CALC cycle -> IDLE next cycle, resp_valid never asserts. A following MULHU 0xFFFF0000 * 0x00010000 -> 0x0000FFFF.
- Reset mid-CALC -> all outputs at reset values next cycle. Flush and req_valid together in IDLE -> no acceptance, state stays IDLE.
